// File: rtl/dfr_batch_scheduler.sv
// Batch scheduler for a DFR core: issues one core_start per sample and walks the
// input/result addresses by their strides, with ack timeout, abort and drain handling.
module dfr_batch_scheduler #(
    parameter int unsigned ADDR_WIDTH  = 32,
    parameter int unsigned CNT_WIDTH   = 16,
    parameter int unsigned ACK_TIMEOUT = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  abort,
    input  logic [CNT_WIDTH-1:0]  num_samples,
    input  logic [ADDR_WIDTH-1:0] in_base,
    input  logic [ADDR_WIDTH-1:0] in_stride,
    input  logic [ADDR_WIDTH-1:0] out_base,
    input  logic [ADDR_WIDTH-1:0] out_stride,
    input  logic                  core_busy,
    output logic                  core_start,
    output logic [ADDR_WIDTH-1:0] core_in_addr,
    output logic [ADDR_WIDTH-1:0] core_out_addr,
    output logic [CNT_WIDTH-1:0]  sample_idx,
    output logic                  busy,
    output logic                  done,
    output logic                  error
);

    localparam int unsigned TMR_W = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;

    typedef enum logic [2:0] {
        IDLE,
        LAUNCH,
        WAIT_ACK,
        WAIT_DONE,
        ADVANCE,
        DRAIN
    } state_e;

    state_e                state_q, state_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  error_q, error_d;
    logic                  core_start_q, core_start_d;
    logic [CNT_WIDTH-1:0]  idx_q, idx_d;
    logic [CNT_WIDTH-1:0]  num_q, num_d;
    logic [ADDR_WIDTH-1:0] in_addr_q, in_addr_d;
    logic [ADDR_WIDTH-1:0] out_addr_q, out_addr_d;
    logic [ADDR_WIDTH-1:0] in_stride_q, in_stride_d;
    logic [ADDR_WIDTH-1:0] out_stride_q, out_stride_d;
    logic [TMR_W-1:0]      timer_q, timer_d;

    // Next-state and registered-output logic; abort always takes priority over progress.
    always_comb begin
        state_d      = state_q;
        done_d       = done_q;
        error_d      = error_q;
        core_start_d = 1'b0;
        idx_d        = idx_q;
        num_d        = num_q;
        in_addr_d    = in_addr_q;
        out_addr_d   = out_addr_q;
        in_stride_d  = in_stride_q;
        out_stride_d = out_stride_q;
        timer_d      = timer_q;

        case (state_q)
            IDLE: begin
                if (start && !abort) begin
                    num_d        = num_samples;
                    in_stride_d  = in_stride;
                    out_stride_d = out_stride;
                    in_addr_d    = in_base;
                    out_addr_d   = out_base;
                    idx_d        = '0;
                    error_d      = 1'b0;
                    if (num_samples == '0) begin
                        done_d = 1'b1;
                    end else begin
                        done_d       = 1'b0;
                        state_d      = LAUNCH;
                        core_start_d = 1'b1;
                    end
                end
            end
            LAUNCH: begin
                if (abort) begin
                    state_d = IDLE;
                    error_d = 1'b1;
                end else begin
                    state_d = WAIT_ACK;
                    timer_d = '0;
                end
            end
            WAIT_ACK: begin
                if (abort) begin
                    state_d = DRAIN;
                end else if (core_busy) begin
                    state_d = WAIT_DONE;
                end else if (timer_q == TMR_W'(ACK_TIMEOUT - 1)) begin
                    state_d = IDLE;
                    error_d = 1'b1;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            WAIT_DONE: begin
                if (abort) begin
                    state_d = DRAIN;
                end else if (!core_busy) begin
                    state_d = ADVANCE;
                end
            end
            ADVANCE: begin
                if (abort) begin
                    state_d = IDLE;
                    error_d = 1'b1;
                end else if (CNT_WIDTH'(idx_q + 1'b1) == num_q) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end else begin
                    idx_d        = idx_q + 1'b1;
                    in_addr_d    = in_addr_q + in_stride_q;
                    out_addr_d   = out_addr_q + out_stride_q;
                    state_d      = LAUNCH;
                    core_start_d = 1'b1;
                end
            end
            DRAIN: begin
                if (!core_busy) begin
                    state_d = IDLE;
                    error_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
            core_start_q <= 1'b0;
            idx_q        <= '0;
            num_q        <= '0;
            in_addr_q    <= '0;
            out_addr_q   <= '0;
            in_stride_q  <= '0;
            out_stride_q <= '0;
            timer_q      <= '0;
        end else begin
            state_q      <= state_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            error_q      <= error_d;
            core_start_q <= core_start_d;
            idx_q        <= idx_d;
            num_q        <= num_d;
            in_addr_q    <= in_addr_d;
            out_addr_q   <= out_addr_d;
            in_stride_q  <= in_stride_d;
            out_stride_q <= out_stride_d;
            timer_q      <= timer_d;
        end
    end

    assign core_start    = core_start_q;
    assign core_in_addr  = in_addr_q;
    assign core_out_addr = out_addr_q;
    assign sample_idx    = idx_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign error         = error_q;

endmodule

// File: tb/tb_dfr_batch_scheduler.sv
// Scoreboard bench for dfr_batch_scheduler: an open-loop driver predicts cycle-exact
// events from a schedule of core ack/busy times; a negedge monitor checks them.
module tb_dfr_batch_scheduler;

    localparam int unsigned AW = 32;
    localparam int unsigned CW = 16;
    localparam int          T  = 16;

    localparam int EV_START = 0;
    localparam int EV_END   = 1;
    localparam int EV_RST   = 2;

    logic          clk = 1'b0;
    logic          rst, start, abort, core_busy;
    logic [CW-1:0] num_samples;
    logic [AW-1:0] in_base, in_stride, out_base, out_stride;
    logic          core_start, busy, done, error;
    logic [AW-1:0] core_in_addr, core_out_addr;
    logic [CW-1:0] sample_idx;

    always #5 clk = ~clk;

    dfr_batch_scheduler #(
        .ADDR_WIDTH (AW),
        .CNT_WIDTH  (CW),
        .ACK_TIMEOUT(T)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .abort        (abort),
        .num_samples  (num_samples),
        .in_base      (in_base),
        .in_stride    (in_stride),
        .out_base     (out_base),
        .out_stride   (out_stride),
        .core_busy    (core_busy),
        .core_start   (core_start),
        .core_in_addr (core_in_addr),
        .core_out_addr(core_out_addr),
        .sample_idx   (sample_idx),
        .busy         (busy),
        .done         (done),
        .error        (error)
    );

    typedef struct {
        int          kind;
        int          cyc;
        int          idx;
        logic [AW-1:0] ia;
        logic [AW-1:0] oa;
        bit          dn;
        bit          er;
    } ev_t;

    ev_t  sb[$];
    ev_t  mon_e;
    int   iv_lo[$];
    int   iv_hi[$];
    int   cyc = 0;
    int   errors = 0;
    int   checks = 0;
    bit   armed = 1'b0;
    logic rst_s = 1'b0;
    logic prev_busy, prev_done, prev_error;

    always @(posedge clk) begin
        cyc   <= cyc + 1;
        rst_s <= rst;
    end

    function automatic void chk(string nm, logic [127:0] act, logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endfunction

    function automatic void push_ev(int k, int c, int idx, logic [AW-1:0] ia, logic [AW-1:0] oa,
                                    bit dn, bit er);
        ev_t e;
        e.kind = k; e.cyc = c; e.idx = idx; e.ia = ia; e.oa = oa; e.dn = dn; e.er = er;
        sb.push_back(e);
    endfunction

    function automatic bit pop_ev(output ev_t e, input int kind);
        e = '{default: 0};
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_output: got event kind %0d at cycle %0d, expected none", kind, cyc);
            return 1'b0;
        end
        e = sb.pop_front();
        chk("event_kind", 128'(kind), 128'(e.kind));
        return (e.kind == kind);
    endfunction

    function automatic bit busy_at(int c);
        foreach (iv_lo[i]) if (c >= iv_lo[i] && c <= iv_hi[i]) return 1'b1;
        return 1'b0;
    endfunction

    // Monitor: every visible DUT event is matched against the next expected one.
    always @(negedge clk) begin
        if (armed) begin
            if (rst_s === 1'b1) begin
                if (pop_ev(mon_e, EV_RST)) begin
                    chk("rst_cycle", 128'(cyc), 128'(mon_e.cyc));
                    chk("rst_outputs", {busy, done, error, core_start, sample_idx, core_in_addr,
                                        core_out_addr}, '0);
                end
            end else begin
                if (core_start === 1'b1 && pop_ev(mon_e, EV_START)) begin
                    chk("start_cycle", 128'(cyc), 128'(mon_e.cyc));
                    chk("start_idx", 128'(sample_idx), 128'(mon_e.idx));
                    chk("start_in_addr", 128'(core_in_addr), 128'(mon_e.ia));
                    chk("start_out_addr", 128'(core_out_addr), 128'(mon_e.oa));
                    chk("start_flags", {busy, done, error}, 128'(3'b100));
                end
                if ((prev_busy === 1'b1 && busy === 1'b0) || (done === 1'b1 && prev_done === 1'b0) ||
                    (error === 1'b1 && prev_error === 1'b0)) begin
                    if (pop_ev(mon_e, EV_END)) begin
                        chk("end_cycle", 128'(cyc), 128'(mon_e.cyc));
                        chk("end_flags", {busy, done, error, core_start},
                            128'({1'b0, mon_e.dn, mon_e.er, 1'b0}));
                    end
                end
            end
        end
        prev_busy  = busy;
        prev_done  = done;
        prev_error = error;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; start = 1'b0; abort = 1'b0; core_busy = 1'b0;
        push_ev(EV_RST, cyc + 1, 0, '0, '0, 1'b0, 1'b0);
        tick();
        rst = 1'b0;
    endtask

    // One batch: a_fix<0 / b_fix<=0 pick random ack delay / busy length per sample;
    // to_s = sample that never gets acked; ab_s/rs_s = sample hit by abort/rst at offset
    // from its LAUNCH cycle (negative offset = random legal offset).
    task automatic run_batch(input int n, input logic [AW-1:0] ib, input logic [AW-1:0] is,
                             input logic [AW-1:0] ob, input logic [AW-1:0] os,
                             input int a_fix, input int b_fix, input int to_s,
                             input int ab_s, input int ab_off, input int rs_s, input int rs_off);
        int t0, lc, endc, stopc, abc, rsc, cur;
        bit fin;
        t0 = cyc; lc = t0 + 1; endc = t0 + 1; abc = -1; rsc = -1; fin = 1'b0;
        iv_lo.delete();
        iv_hi.delete();
        start = 1'b1; abort = 1'b0; rst = 1'b0; core_busy = 1'b0;
        num_samples = CW'(n); in_base = ib; in_stride = is; out_base = ob; out_stride = os;
        if (n == 0) push_ev(EV_END, t0 + 1, 0, '0, '0, 1'b1, 1'b0);
        for (int s = 0; s < n && !fin; s++) begin
            int a, b, v, lim, off;
            bit tmo;
            logic [AW-1:0] ia, oa;
            a   = (s == to_s) ? T : ((a_fix >= 0) ? a_fix : int'($urandom_range(0, 3)));
            b   = (b_fix > 0) ? b_fix : int'($urandom_range(1, 6));
            tmo = (a >= T);
            v   = lc + a + b + 2;
            ia  = ib + is * AW'(s);
            oa  = ob + os * AW'(s);
            push_ev(EV_START, lc, s, ia, oa, 1'b0, 1'b0);
            if (!tmo) begin
                iv_lo.push_back(lc + 1 + a);
                iv_hi.push_back(lc + a + b);
            end
            if (s == rs_s) begin
                off  = (rs_off >= 0) ? rs_off : int'($urandom_range(a + 2, a + b + 1));
                rsc  = lc + off;
                endc = rsc + 1;
                push_ev(EV_RST, endc, 0, '0, '0, 1'b0, 1'b0);
                fin = 1'b1;
            end else if (s == ab_s) begin
                lim = tmo ? T : a + b + 2;
                off = (ab_off >= 0) ? ab_off : int'($urandom_range(0, lim));
                if (off > lim) off = lim;
                abc = lc + off;
                if (off == 0 || (!tmo && off == lim)) begin
                    endc = abc + 1;
                end else begin
                    int d;
                    d = abc + 1;
                    while (busy_at(d)) d++;
                    endc = d + 1;
                end
                push_ev(EV_END, endc, 0, '0, '0, 1'b0, 1'b1);
                fin = 1'b1;
            end else if (tmo) begin
                endc = lc + 1 + T;
                push_ev(EV_END, endc, 0, '0, '0, 1'b0, 1'b1);
                fin = 1'b1;
            end else if (s == n - 1) begin
                endc = v + 1;
                push_ev(EV_END, endc, 0, '0, '0, 1'b1, 1'b0);
                fin = 1'b1;
            end else begin
                lc = v + 1;
            end
        end
        stopc = endc;
        foreach (iv_hi[i]) if (iv_hi[i] + 1 > stopc) stopc = iv_hi[i] + 1;
        do begin
            tick();
            cur = cyc;
            num_samples = CW'($urandom);
            in_base = $urandom; in_stride = $urandom; out_base = $urandom; out_stride = $urandom;
            start     = (cur < endc && cur != rsc) ? ($urandom_range(0, 2) == 0) : 1'b0;
            abort     = (cur == abc) || (cur >= endc && $urandom_range(0, 3) == 0);
            rst       = (cur == rsc);
            core_busy = busy_at(cur);
        end while (cur < stopc);
        tick();
        start = 1'b0; abort = 1'b0; rst = 1'b0; core_busy = 1'b0;
    endtask

    initial begin
        int n, ab_s, rs_s, to_s;
        rst = 1'b1; start = 1'b0; abort = 1'b0; core_busy = 1'b0;
        num_samples = '0; in_base = '0; in_stride = '0; out_base = '0; out_stride = '0;
        repeat (2) tick();
        push_ev(EV_RST, cyc, 0, '0, '0, 1'b0, 1'b0);
        armed = 1'b1;
        rst = 1'b0;
        tick();

        // Three samples, 5-cycle core busy
        run_batch(3, 32'h100, 32'h20, 32'h8000, 32'h40, 2, 5, -1, -1, 0, -1, 0);
        // Empty batch
        do_reset();
        run_batch(0, 32'h200, 32'h4, 32'h300, 32'h4, 0, 1, -1, -1, 0, -1, 0);
        // Ack timeout on the first sample
        run_batch(2, 32'h400, 32'h10, 32'h500, 32'h10, 1, 3, 0, -1, 0, -1, 0);
        // Abort in WAIT_DONE with core busy for four more cycles
        run_batch(3, 32'h600, 32'h8, 32'h700, 32'h8, 1, 6, -1, 1, 3, -1, 0);
        // Address wrap
        run_batch(2, 32'hFFFF_FFF0, 32'h20, 32'hFFFF_FF00, 32'h80, 0, 2, -1, -1, 0, -1, 0);
        // Reset mid WAIT_DONE, then a clean batch
        run_batch(3, 32'h800, 32'h10, 32'h900, 32'h10, 1, 5, -1, 1, 0, 1, 4);
        run_batch(2, 32'hA00, 32'h10, 32'hB00, 32'h10, 0, 2, -1, -1, 0, -1, 0);
        // Abort in LAUNCH, WAIT_ACK and ADVANCE
        run_batch(2, 32'h10, 32'h4, 32'h20, 32'h4, 2, 2, -1, 0, 0, -1, 0);
        run_batch(2, 32'h10, 32'h4, 32'h20, 32'h4, 2, 2, -1, 1, 1, -1, 0);
        run_batch(2, 32'h10, 32'h4, 32'h20, 32'h4, 2, 2, -1, 0, 6, -1, 0);

        // Abort and start together in IDLE: start must be dropped
        start = 1'b1; abort = 1'b1; num_samples = 16'd2;
        tick();
        start = 1'b0; abort = 1'b0;
        @(negedge clk);
        chk("abort_start_idle", {busy, core_start}, '0);
        repeat (4) tick();

        for (int k = 0; k < 40; k++) begin
            n    = int'($urandom_range(0, 5));
            to_s = -1; ab_s = -1; rs_s = -1;
            if (n == 0) begin
                do_reset();
            end else begin
                case ($urandom_range(0, 5))
                    0: to_s = int'($urandom_range(0, n - 1));
                    1: ab_s = int'($urandom_range(0, n - 1));
                    2: rs_s = int'($urandom_range(0, n - 1));
                    default: ;
                endcase
            end
            run_batch(n, $urandom, $urandom, $urandom, $urandom, -1, 0, to_s, ab_s, -1, rs_s, -1);
        end

        repeat (3) tick();
        chk("scoreboard_empty", 128'(sb.size()), '0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
